// File: rtl/uart_fifo_trig.sv
// UART data/status FIFO with occupancy level, trigger select, flush, sticky overrun and error tracking.
// Optional character-timeout detection is built when UART_FIFO_TIMEOUT_EN is defined.
module uart_fifo_trig #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TAG_WIDTH      = 3,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TRIG0          = 1,
  parameter int unsigned TRIG1          = 4,
  parameter int unsigned TRIG2          = 8,
  parameter int unsigned TRIG3          = 14,
  parameter int unsigned TIMEOUT_CYCLES = 640,
  localparam int unsigned CW            = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic [TAG_WIDTH-1:0] rd_tag,
  output logic                 rd_valid,
  input  logic                 flush,
  input  logic [1:0]           trig_sel,
  input  logic                 ovr_clr,
  output logic [CW-1:0]        level,
  output logic                 empty,
  output logic                 full,
  output logic                 trig_hit,
  output logic                 overrun,
  output logic                 err_present,
  output logic                 timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = TAG_WIDTH + WIDTH;

  if (DEPTH < 2 || TAG_WIDTH < 1 || TIMEOUT_CYCLES > 65535 ||
      TRIG0 < 1 || TRIG0 > DEPTH || TRIG1 < 1 || TRIG1 > DEPTH ||
      TRIG2 < 1 || TRIG2 > DEPTH || TRIG3 < 1 || TRIG3 > DEPTH) begin : g_param_check
    $error("uart_fifo_trig: illegal parameter set");
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] trig_lvl;
  logic          do_rd;
  logic          do_wr;
  logic          ovr_set;
  logic          err_inc;
  logic          err_dec;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Flush masks both requests; a full FIFO still accepts a write alongside a read.
  assign do_rd   = rd_en && !empty && !flush;
  assign do_wr   = wr_en && (!full || do_rd) && !flush;
  assign ovr_set = wr_en && full && !do_rd && !flush;
  assign err_inc = do_wr && (wr_tag != '0);
  assign err_dec = do_rd && (mem[rd_ptr][EW-1:WIDTH] != '0);

  assign empty       = (level == '0);
  assign full        = (level == CW'(DEPTH));
  assign err_present = (err_cnt != '0);

  always_comb begin
    trig_lvl = CW'(TRIG0);
    case (trig_sel)
      2'd1:    trig_lvl = CW'(TRIG1);
      2'd2:    trig_lvl = CW'(TRIG2);
      2'd3:    trig_lvl = CW'(TRIG3);
      default: trig_lvl = CW'(TRIG0);
    endcase
    trig_hit = (level >= trig_lvl);
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {wr_tag, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      err_cnt  <= '0;
      rd_data  <= '0;
      rd_tag   <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      err_cnt  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) begin
        {rd_tag, rd_data} <= mem[rd_ptr];
        rd_ptr            <= ptr_inc(rd_ptr);
      end
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_wr && !do_rd)      level <= level + CW'(1);
      else if (do_rd && !do_wr) level <= level - CW'(1);
      if (err_inc && !err_dec)      err_cnt <= err_cnt + CW'(1);
      else if (err_dec && !err_inc) err_cnt <= err_cnt - CW'(1);
    end
  end

  // Sticky overrun: a dropped write wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

`ifdef UART_FIFO_TIMEOUT_EN
  logic [15:0] idle_cnt;

  // Idle counter saturates so timeout holds until the next transfer or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     idle_cnt <= '0;
    else if (flush || do_rd || do_wr || empty)      idle_cnt <= '0;
    else if (idle_cnt != 16'(TIMEOUT_CYCLES))       idle_cnt <= idle_cnt + 16'd1;
  end

  assign timeout = (idle_cnt == 16'(TIMEOUT_CYCLES)) && !empty;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_trig.sv
// Directed bench for uart_fifo_trig: reference queue model feeds a scoreboard checked by a read monitor.
module tb_uart_fifo_trig;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned TW    = 3;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [TW-1:0]    wr_tag;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic [TW-1:0]    rd_tag;
  logic             rd_valid;
  logic             flush;
  logic [1:0]       trig_sel;
  logic             ovr_clr;
  logic [CW-1:0]    level;
  logic             empty;
  logic             full;
  logic             trig_hit;
  logic             overrun;
  logic             err_present;
  logic             timeout;

  int errors = 0;
  int checks = 0;

  logic [TW+WIDTH-1:0] mq[$];
  logic [TW+WIDTH-1:0] exp_q[$];

  uart_fifo_trig #(
    .WIDTH(WIDTH), .TAG_WIDTH(TW), .DEPTH(DEPTH),
    .TRIG0(1), .TRIG1(4), .TRIG2(8), .TRIG3(14), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_tag(wr_tag),
    .rd_en(rd_en), .rd_data(rd_data), .rd_tag(rd_tag), .rd_valid(rd_valid),
    .flush(flush), .trig_sel(trig_sel), .ovr_clr(ovr_clr), .level(level),
    .empty(empty), .full(full), .trig_hit(trig_hit), .overrun(overrun),
    .err_present(err_present), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; the model records what each accepted read must return.
  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic [TW-1:0] t,
                     input logic r, input logic f);
    logic mrd, mwr;
    wr_en = w; wr_data = d; wr_tag = t; rd_en = r; flush = f;
    mrd = r && (mq.size() > 0) && !f;
    mwr = w && ((mq.size() < DEPTH) || mrd) && !f;
    @(posedge clk);
    if (f) mq.delete();
    else begin
      if (mrd) exp_q.push_back(mq.pop_front());
      if (mwr) mq.push_back({t, d});
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: each read must appear exactly one cycle after acceptance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got %0h/%0h expected no read", rd_tag, rd_data);
        end else begin
          logic [TW+WIDTH-1:0] e;
          e = exp_q.pop_front();
          chk("rd_word", {21'd0, rd_tag, rd_data}, {21'd0, e});
        end
      end else if (exp_q.size() != 0) begin
        checks++; errors++;
        $display("FAIL rd_missing: got rd_valid=0 expected %0h", exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; wr_tag = '0; rd_en = 1'b0;
    flush = 1'b0; trig_sel = 2'd0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_rd_tag", 32'(rd_tag), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_err", 32'(err_present), 32'h0);
    chk("rst_trig", 32'(trig_hit), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: 15 words in, 15 out in order
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'h11 + 8'(i), '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_level15", 32'(level), 32'd15);
    for (int i = 0; i < 15; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);
    @(negedge clk);
    chk("t1_level0", 32'(level), 32'd0);
    chk("t1_empty", 32'(empty), 32'h1);

    // 2: fill, dropped write sets overrun, clear it
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'h20 + 8'(i), '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_full", 32'(full), 32'h1);
    cyc(1'b1, 8'hAA, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_overrun_set", 32'(overrun), 32'h1);
    chk("t2_level16", 32'(level), 32'd16);
    ovr_clr = 1'b1;
    idle(1);
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("t2_overrun_clr", 32'(overrun), 32'h0);

    // 3: simultaneous read+write at full; 0x55 lands behind 0x21..0x2F
    cyc(1'b1, 8'h55, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t3_level16", 32'(level), 32'd16);
    chk("t3_full", 32'(full), 32'h1);
    chk("t3_no_overrun", 32'(overrun), 32'h0);
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);
    @(negedge clk);
    chk("t3_empty", 32'(empty), 32'h1);

    // 4: trigger levels
    trig_sel = 2'd2;
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h40 + 8'(i), '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_trig_at7", 32'(trig_hit), 32'h0);
    cyc(1'b1, 8'h47, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_trig_at8", 32'(trig_hit), 32'h1);
    trig_sel = 2'd3; #1;
    chk("t4_trig_sel3", 32'(trig_hit), 32'h0);
    trig_sel = 2'd0; #1;
    chk("t4_trig_sel0", 32'(trig_hit), 32'h1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_flush_level", 32'(level), 32'd0);

    // 5: error tracking, then flush with wr/rd in the same cycle
    cyc(1'b1, 8'h30, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 8'h31, 3'd3, 1'b0, 1'b0);
    cyc(1'b1, 8'h32, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_err_set", 32'(err_present), 32'h1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_err_after1", 32'(err_present), 32'h1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_err_clr", 32'(err_present), 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + 8'(i), (i == 2) ? 3'd1 : 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_level6", 32'(level), 32'd6);
    chk("t5_err_again", 32'(err_present), 32'h1);
    cyc(1'b1, 8'h99, 3'd4, 1'b1, 1'b1);
    @(negedge clk);
    chk("t5_flush_level", 32'(level), 32'd0);
    chk("t5_flush_empty", 32'(empty), 32'h1);
    chk("t5_flush_err", 32'(err_present), 32'h0);
    chk("t5_hold_data", 32'(rd_data), 32'h31);
    chk("t5_hold_tag", 32'(rd_tag), 32'h3);
    cyc(1'b1, 8'h77, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);

    // 6: character timeout
    cyc(1'b1, 8'h5A, 3'd0, 1'b0, 1'b0);
`ifdef UART_FIFO_TIMEOUT_EN
    idle(19);
    @(negedge clk);
    chk("t6_timeout_19", 32'(timeout), 32'h0);
    idle(1);
    @(negedge clk);
    chk("t6_timeout_20", 32'(timeout), 32'h1);
    idle(5);
    @(negedge clk);
    chk("t6_timeout_hold", 32'(timeout), 32'h1);
`else
    idle(30);
    @(negedge clk);
    chk("t6_timeout_absent", 32'(timeout), 32'h0);
`endif
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t6_timeout_rd", 32'(timeout), 32'h0);
    idle(30);
    @(negedge clk);
    chk("t6_timeout_empty", 32'(timeout), 32'h0);

    idle(2);
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("model_empty", 32'(empty), 32'(mq.size() == 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_fifo_trig.md
Name: uart_fifo_trig

Overview:
Parametrised successor to the UART's basic buffer FIFO. It stores data words plus per-entry status tags (parity, framing and break flags), and can be used for both the RX and TX paths of the 16550-class UART. It adds the following over the basic FIFO:
- occupancy level output
- selectable trigger level
- synchronous flush
- sticky overrun flag
- error-in-FIFO indication
- optional character-timeout detection

Parameters:
- WIDTH, 8: data word width.
- TAG_WIDTH, 3: per-entry status tag width; must be ≥1.
- DEPTH, 16: number of entries; any value ≥2 (power of two not required).
- TRIG0, 1: trigger level for trig_sel=0.
- TRIG1, 4: trigger level for trig_sel=1.
- TRIG2, 8: trigger level for trig_sel=2.
- TRIG3, 14: trigger level for trig_sel=3. All TRIGn must satisfy 1..DEPTH.
- TIMEOUT_CYCLES, 640: idle cycles before timeout asserts; used only with UART_FIFO_TIMEOUT_EN.
- CW (derived, not overridable): $clog2(DEPTH+1), the count width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- wr_tag  in  TAG_WIDTH  status tag stored with wr_data.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  registered read data.
- rd_tag  out  TAG_WIDTH  registered tag of the read entry.
- rd_valid  out  1  one-cycle pulse; rd_data/rd_tag are valid.
- flush  in  1  synchronous clear of contents.
- trig_sel  in  2  trigger level select.
- ovr_clr  in  1  clears overrun.
- level  out  CW  current occupancy, 0..DEPTH.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- trig_hit  out  1  level ≥ selected trigger level.
- overrun  out  1  sticky: a write was dropped.
- err_present  out  1  at least one stored entry has a nonzero tag.
- timeout  out  1  character timeout (0 when the feature is absent).

Behaviour:
- Reset (rst_n=0, asynchronous): pointers, level and error count go to 0; timeout counter goes to 0. Outputs:
  - rd_data=0, rd_tag=0, rd_valid=0, overrun=0, timeout=0
  - empty=1, full=0, err_present=0
  - trig_hit=0
- Reset mid-operation discards all contents.
- Read acceptance: do_rd = rd_en && !empty.
- Write acceptance: do_wr = wr_en && (!full || do_rd). When full, a simultaneous read and write are both accepted.
- Empty with simultaneous read and write: the write is accepted, the read is rejected. There is no bypass.
- Write: mem[wr_ptr] ← {wr_tag, wr_data}; wr_ptr advances.
- Read latency: 1 cycle. On do_rd:
  - rd_data and rd_tag ← mem[rd_ptr] on the next edge.
  - rd_valid=1 for that cycle, otherwise 0.
  - rd_data and rd_tag hold their last value when no read occurs.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. Each pointer is a $clog2(DEPTH)-bit register.
- Level update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both or neither occur.
- Overrun:
  - Set on wr_en && full && !do_rd; the write is dropped and contents are unchanged.
  - Cleared by ovr_clr.
  - Set has priority over clear in the same cycle.
  - flush does not clear overrun.
- Error count (CW bits):
  - +1 on an accepted write with wr_tag≠0.
  - -1 on an accepted read whose entry tag≠0.
  - Both in the same cycle leaves it unchanged.
  - err_present = (error count ≠ 0).
- trig_hit: combinational, level ≥ TRIGn for n = trig_sel.
- Flush:
  - On the next edge: pointers, level and error count go to 0, and rd_valid=0.
  - Overrides wr_en and rd_en in the same cycle; both are ignored.
  - rd_data and rd_tag are held.
- empty, full, err_present and trig_hit are combinational from registered state.

Optional Feature:
UART_FIFO_TIMEOUT_EN
- Defined: a 16-bit idle counter controls timeout.
  - The counter clears on any accepted read or write, on flush, or while empty.
  - Otherwise it increments, saturating at TIMEOUT_CYCLES.
  - timeout = (counter == TIMEOUT_CYCLES) && !empty.
  - timeout stays asserted until the next accepted read or write, or a flush.
- Undefined: no counter is built and timeout is tied to 0.

Test Plan:
1. Reset, then write 0x11..0x1F (15 words), then read all 15 → read data returns 0x11..0x1F in order. For each, rd_valid pulses 1 cycle after rd_en. level goes 15→0 and empty=1 at the end.
2. Fill to 16, issue wr_en alone with 0xAA → overrun=1, level stays 16, and 0xAA is never read. Pulse ovr_clr → overrun=0.
3. At full, simultaneous wr_en(0x55) and rd_en → level stays 16 and full stays 1. 0x55 is read as the 16th word after the 15 remaining older words.
4. trig_sel=2, write 7 words → trig_hit=0; write an 8th → trig_hit=1. Switch trig_sel=3 → trig_hit=0.
5. Write tags 0,3,0 → err_present=1. Reading 2 entries drops the count to 0 → err_present=0. Write 5 words, then flush together with wr_en → level=0, empty=1, and the flush-cycle write is not stored.
6. (UART_FIFO_TIMEOUT_EN, TIMEOUT_CYCLES=20) Write 1 word then idle → timeout=1 exactly 20 cycles after the write. A read clears it. Idling while empty keeps timeout=0.
